seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider for W-bit operands with a start/busy/done handshake.
- Generation after the fixed 8-bit unsigned iterative divider; adds signed mode, divide-by-zero and overflow flags, and held results.
- Produces one quotient bit per cycle.
- Used as a shared arithmetic unit behind a simple controller. The controller issues start and waits for done.

---
 rtl/seq_divider.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, optional two's-complement
// operands, divide-by-zero and signed-overflow flags, results held until the next completion.
module seq_divider #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow,
    output logic [1:0]   dbg_state_o
);

    // Handshake: start is taken only on an edge where busy=0; operands and is_signed are
    // sampled on that edge. done pulses for one cycle with busy already low, so the
    // controller may issue the next start in the done cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic           a_neg_q, a_neg_d;
    logic           b_neg_q, b_neg_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic           dbz_pend_q, dbz_pend_d;
    logic           ovf_pend_q, ovf_pend_d;
    logic [W-1:0]   quotient_q, quotient_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic           in_a_neg, in_b_neg;
    logic [W-1:0]   in_a_mag, in_b_mag;
    logic [W+1:0]   trial;
    logic           trial_neg;

    always_comb begin
        in_a_neg = is_signed & dividend[W-1];
        in_b_neg = is_signed & divisor[W-1];
        in_a_mag = in_a_neg ? -dividend : dividend;
        in_b_mag = in_b_neg ? -divisor  : divisor;
    end

    // Partial remainder stays below the divisor, so {rem, bit} < 2^(W+1) and a
    // W+2-bit difference carries a reliable sign in its MSB.
    always_comb begin
        trial     = {rem_q, dvd_q[W-1]} - {2'b00, dvs_q};
        trial_neg = trial[W+1];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dbz_pend_d  = dbz_pend_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sgn_d      = is_signed;
                    a_neg_d    = in_a_neg;
                    b_neg_d    = in_b_neg;
                    dvs_d      = in_b_mag;
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = CW'(W);
                    dbz_pend_d = (divisor == '0);
                    ovf_pend_d = is_signed && (dividend == MIN_NEG) && (divisor == '1);
                    if (divisor == '0) begin
                        // Raw dividend is kept so it can be returned unmodified.
                        dvd_d   = dividend;
                        state_d = S_FIX;
                    end else begin
                        dvd_d   = in_a_mag;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (trial_neg) begin
                    rem_d = {rem_q[W-1:0], dvd_q[W-1]};
                end else begin
                    rem_d = trial[W:0];
                end
                quo_d = {quo_q[W-2:0], ~trial_neg};
                dvd_d = {dvd_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (dbz_pend_q) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                    ovf_d       = 1'b0;
                end else begin
                    quotient_d  = (sgn_q && (a_neg_q != b_neg_q)) ? -quo_q : quo_q;
                    remainder_d = (sgn_q && a_neg_q) ? -rem_q[W-1:0] : rem_q[W-1:0];
                    dbz_d       = 1'b0;
                    ovf_d       = ovf_pend_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dbz_pend_q  <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dbz_pend_q  <= dbz_pend_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic/latency model checked every cycle, plus directed
// operations with hand-computed results.
module tb_seq_divider;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Result packed as {quotient, remainder, div_by_zero, overflow}.
    function automatic logic [2*W+1:0] ref_div(input logic sg, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint sa, sb, q, r, lim;
        logic   ov;
        if (b == '0) return {{W{1'b1}}, a, 1'b1, 1'b0};
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q   = sa / sb;
        r   = sa % sb;
        lim = 1;
        lim = lim << (W - 1);
        ov  = sg && (q == lim);
        return {q[W-1:0], r[W-1:0], 1'b0, ov};
    endfunction

    // Timing: an accepted op completes W+1 edges later (1 edge on divide-by-zero);
    // results and flags then hold until the next completion.
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_q    = '0;
    logic [W-1:0] m_r    = '0;
    logic         m_dbz  = 1'b0;
    logic         m_ovf  = 1'b0;
    logic [W-1:0] p_q    = '0;
    logic [W-1:0] p_r    = '0;
    logic         p_dbz  = 1'b0;
    logic         p_ovf  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_dbz  <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_q    <= p_q;
                    m_r    <= p_r;
                    m_dbz  <= p_dbz;
                    m_ovf  <= p_ovf;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                {p_q, p_r, p_dbz, p_ovf} <= ref_div(is_signed, dividend, divisor);
                m_cnt <= (divisor == '0) ? 1 : W + 1;
            end
        end
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        chk1("cyc_done", done, m_done);
        chk1("cyc_busy", busy, m_cnt != 0);
        chk("cyc_quotient", quotient, m_q);
        chk("cyc_remainder", remainder, m_r);
        chk1("cyc_div_by_zero", div_by_zero, m_dbz);
        chk1("cyc_overflow", overflow, m_ovf);
    end

    // ---------------- driver ----------------
    task automatic pin(input string nm, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eov);
        logic [2*W+1:0] r;
        r = ref_div(sg, a, b);
        chk({nm, "_q"}, r[2*W+1:W+2], eq);
        chk({nm, "_r"}, r[W+1:2], er);
        chk1({nm, "_dbz"}, r[1], edz);
        chk1({nm, "_ovf"}, r[0], eov);
    endtask

    // Issues one op, optionally pulses a stray start at iteration 'inj', waits for done
    // (bounded) and compares against literal expectations including latency.
    task automatic do_op(input string nm, input bit at_once, input logic sg,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov, input int elat, input int inj);
        int lat;
        bit seen;
        if (!at_once) @(negedge clk);
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (lat == inj);
            if (lat == inj) begin
                is_signed = ~sg;
                dividend  = 8'h55;
                divisor   = 8'h00;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
        end else begin
            chk({nm, "_latency"}, W'(lat), W'(elat));
            chk({nm, "_quotient"}, quotient, eq);
            chk({nm, "_remainder"}, remainder, er);
            chk1({nm, "_div_by_zero"}, div_by_zero, edz);
            chk1({nm, "_overflow"}, overflow, eov);
            chk1({nm, "_busy_low"}, busy, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;

        pin("pin_u100_7", 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        pin("pin_s_m7_2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0);
        pin("pin_s_ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
        pin("pin_dbz", 1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 8'h00);
        chk("rst_remainder", remainder, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_div_by_zero", div_by_zero, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_state_idle", dbg_state == 2'd0, 1'b1);
        #2 reset = 1'b0;

        do_op("u100_7", 1'b0, 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9, -1);
        do_op("s_m7_2", 1'b0, 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 9, -1);
        do_op("s_7_m2", 1'b0, 1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 9, -1);
        do_op("u_dbz", 1'b0, 1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 1, -1);
        do_op("s_dbz", 1'b0, 1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 1'b1, 1'b0, 1, -1);
        do_op("s_ovf", 1'b0, 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9, -1);
        do_op("u_80_ff", 1'b0, 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 9, -1);
        do_op("s_m127_3", 1'b0, 1'b1, 8'h81, 8'h03, 8'hD6, 8'hFF, 1'b0, 1'b0, 9, -1);
        do_op("u_ff_1", 1'b0, 1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9, -1);
        do_op("u_5_9", 1'b0, 1'b0, 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 9, -1);

        // Stray start with new operands mid-operation must not disturb the result.
        do_op("mid_start", 1'b0, 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 9, 3);

        // Second start issued in the done cycle of the first.
        do_op("b2b_first", 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h10, 8'h00, 1'b0, 1'b0, 9, -1);
        do_op("b2b_second", 1'b1, 1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9, -1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 8'hC8;
        divisor   = 8'h03;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_quotient", quotient, 8'h00);
        chk("areset_remainder", remainder, 8'h00);
        chk1("areset_busy", busy, 1'b0);
        chk1("areset_done", done, 1'b0);
        chk1("areset_div_by_zero", div_by_zero, 1'b0);
        chk1("areset_overflow", overflow, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;

        do_op("after_reset", 1'b0, 1'b0, 8'd200, 8'd10, 8'd20, 8'd0, 1'b0, 1'b0, 9, -1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
